// File: rtl/coef_loader.sv
// Byte-stream coefficient loader: assembles framed a-/b-sets and commits them atomically.
// Optional trailing XOR checksum byte is enabled by defining COEF_LOADER_CHECKSUM_EN.
module coef_loader #(
  parameter int         WIDTH     = 27,
  parameter int         ORDER_IIR = 2,
  parameter logic [7:0] HDR_A     = 8'hA1,
  parameter logic [7:0] HDR_B     = 8'hB1
) (
  input  logic                                ic_clk,
  input  logic                                ic_rst_n,
  input  logic [7:0]                          id_byte,
  input  logic                                ic_byte_val,
  output logic                                oc_byte_rdy,
  input  logic                                ic_abort,
  output logic [ORDER_IIR-1:0][WIDTH-1:0]     od_coef_a,
  output logic [ORDER_IIR:0][WIDTH-1:0]       od_coef_b,
  output logic                                oc_val_coef_a,
  output logic                                oc_val_coef_b,
  output logic                                oc_err,
  output logic                                oc_busy
);

  localparam int BPC  = (WIDTH + 7) / 8;
  localparam int NMAX = ORDER_IIR + 1;
  localparam int BCW  = $clog2(BPC + 1);
  localparam int CCW  = $clog2(NMAX + 1);

`ifdef COEF_LOADER_CHECKSUM_EN
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CHK, S_COMMIT} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMMIT} state_t;
`endif

  state_t                       r_state;
  logic                         r_sel_b;
  logic [BCW-1:0]               r_byte_cnt;
  logic [CCW-1:0]               r_coef_cnt;
  logic [WIDTH-1:0]             r_asm;
  logic [NMAX-1:0][WIDTH-1:0]   r_shadow;
`ifdef COEF_LOADER_CHECKSUM_EN
  logic [7:0]                   r_csum;
  logic                         w_ck_bad;
`endif

  logic                         w_acc;
  logic [WIDTH-1:0]             w_word;
  logic                         w_last_byte;
  logic                         w_last_coef;
  logic                         w_commit;
  logic [NMAX-1:0][WIDTH-1:0]   w_shadow_upd;
  logic [NMAX-1:0][WIDTH-1:0]   w_src;

  assign w_acc       = ic_byte_val & oc_byte_rdy;
  // Bits shifted past WIDTH are dropped each step, equivalent to keeping the low WIDTH bits.
  assign w_word      = WIDTH'({r_asm, id_byte});
  assign w_last_byte = (r_byte_cnt == BCW'(BPC - 1));
  assign w_last_coef = r_sel_b ? (r_coef_cnt == CCW'(ORDER_IIR))
                               : (r_coef_cnt == CCW'(ORDER_IIR - 1));
  assign oc_busy     = (r_state != S_IDLE);

  always_comb begin
    w_shadow_upd = r_shadow;
    if (w_last_byte) w_shadow_upd[r_coef_cnt] = w_word;
  end

  // Commit happens on the edge that accepts the final frame byte, so the final word is
  // taken straight from the byte bus rather than waiting for the shadow write.
  always_comb begin
    w_commit = 1'b0;
    w_src    = w_shadow_upd;
`ifdef COEF_LOADER_CHECKSUM_EN
    w_ck_bad = 1'b0;
    if (w_acc && !ic_abort && r_state == S_CHK) begin
      w_src = r_shadow;
      if (id_byte == r_csum) w_commit = 1'b1;
      else                   w_ck_bad = 1'b1;
    end
`else
    if (w_acc && !ic_abort && r_state == S_LOAD && w_last_byte && w_last_coef) w_commit = 1'b1;
`endif
  end

  always_ff @(posedge ic_clk or negedge ic_rst_n) begin
    if (!ic_rst_n) begin
      r_state       <= S_IDLE;
      r_sel_b       <= 1'b0;
      r_byte_cnt    <= '0;
      r_coef_cnt    <= '0;
      r_asm         <= '0;
      r_shadow      <= '0;
`ifdef COEF_LOADER_CHECKSUM_EN
      r_csum        <= '0;
`endif
      od_coef_a     <= '0;
      od_coef_b     <= '0;
      oc_val_coef_a <= 1'b0;
      oc_val_coef_b <= 1'b0;
      oc_err        <= 1'b0;
      oc_byte_rdy   <= 1'b0;
    end else begin
      oc_val_coef_a <= 1'b0;
      oc_val_coef_b <= 1'b0;
      oc_err        <= 1'b0;
      oc_byte_rdy   <= 1'b1;

      if (w_commit) begin
        if (r_sel_b) begin
          od_coef_b     <= w_src;
          oc_val_coef_b <= 1'b1;
        end else begin
          for (int i = 0; i < ORDER_IIR; i++) od_coef_a[i] <= w_src[i];
          oc_val_coef_a <= 1'b1;
        end
      end

      if (r_state != S_IDLE && ic_abort) begin
        r_state    <= S_IDLE;
        r_byte_cnt <= '0;
        r_coef_cnt <= '0;
        r_asm      <= '0;
        r_shadow   <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_acc) begin
              if (id_byte == HDR_A || id_byte == HDR_B) begin
                r_sel_b    <= (id_byte == HDR_B);
                r_byte_cnt <= '0;
                r_coef_cnt <= '0;
                r_asm      <= '0;
`ifdef COEF_LOADER_CHECKSUM_EN
                r_csum     <= id_byte;
`endif
                r_state    <= S_LOAD;
              end else begin
                oc_err <= 1'b1;
              end
            end
          end
          S_LOAD: begin
            if (w_acc) begin
`ifdef COEF_LOADER_CHECKSUM_EN
              r_csum <= r_csum ^ id_byte;
`endif
              if (w_last_byte) begin
                r_shadow   <= w_shadow_upd;
                r_byte_cnt <= '0;
                r_coef_cnt <= r_coef_cnt + 1'b1;
                r_asm      <= '0;
                if (w_last_coef) begin
`ifdef COEF_LOADER_CHECKSUM_EN
                  r_state     <= S_CHK;
`else
                  r_state     <= S_COMMIT;
                  oc_byte_rdy <= 1'b0;
`endif
                end
              end else begin
                r_byte_cnt <= r_byte_cnt + 1'b1;
                r_asm      <= w_word;
              end
            end
          end
`ifdef COEF_LOADER_CHECKSUM_EN
          S_CHK: begin
            if (w_commit) begin
              r_state     <= S_COMMIT;
              oc_byte_rdy <= 1'b0;
            end else if (w_ck_bad) begin
              r_state  <= S_IDLE;
              r_shadow <= '0;
              oc_err   <= 1'b1;
            end
          end
`endif
          S_COMMIT: r_state <= S_IDLE;
          default:  r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_coef_loader.sv
// Directed, table-driven bench for coef_loader (default parameters).
module tb_coef_loader;

  logic              ic_clk;
  logic              ic_rst_n;
  logic [7:0]        id_byte;
  logic              ic_byte_val;
  logic              oc_byte_rdy;
  logic              ic_abort;
  logic [1:0][26:0]  od_coef_a;
  logic [2:0][26:0]  od_coef_b;
  logic              oc_val_coef_a;
  logic              oc_val_coef_b;
  logic              oc_err;
  logic              oc_busy;

  int n_vec  = 0;
  int n_miss = 0;

  coef_loader dut (
    .ic_clk        (ic_clk),
    .ic_rst_n      (ic_rst_n),
    .id_byte       (id_byte),
    .ic_byte_val   (ic_byte_val),
    .oc_byte_rdy   (oc_byte_rdy),
    .ic_abort      (ic_abort),
    .od_coef_a     (od_coef_a),
    .od_coef_b     (od_coef_b),
    .oc_val_coef_a (oc_val_coef_a),
    .oc_val_coef_b (oc_val_coef_b),
    .oc_err        (oc_err),
    .oc_busy       (oc_busy)
  );

  initial ic_clk = 1'b0;
  always #5 ic_clk = ~ic_clk;

  // Bytes are right-aligned: the last frame byte sits in by[7:0].
  typedef struct packed {
    logic [103:0] by;
    logic [3:0]   nb;
    logic [1:0]   gap;
    logic         ck;
    logic         e_err;
    logic         e_va;
    logic         e_vb;
    logic [26:0]  ea0, ea1, eb0, eb1, eb2;
  } vec_t;

  function automatic vec_t mkvec(input logic [103:0] by, input logic [3:0] nb,
                                 input logic [1:0] gap, input logic ck,
                                 input logic e_err, input logic e_va, input logic e_vb,
                                 input logic [26:0] ea0, input logic [26:0] ea1,
                                 input logic [26:0] eb0, input logic [26:0] eb1,
                                 input logic [26:0] eb2);
    vec_t v;
    v.by = by; v.nb = nb; v.gap = gap; v.ck = ck;
    v.e_err = e_err; v.e_va = e_va; v.e_vb = e_vb;
    v.ea0 = ea0; v.ea1 = ea1; v.eb0 = eb0; v.eb1 = eb1; v.eb2 = eb2;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_coefs(input string tag, input logic [26:0] ea0, input logic [26:0] ea1,
                           input logic [26:0] eb0, input logic [26:0] eb1, input logic [26:0] eb2);
    chk({tag, ".a0"}, 32'(od_coef_a[0]), 32'(ea0));
    chk({tag, ".a1"}, 32'(od_coef_a[1]), 32'(ea1));
    chk({tag, ".b0"}, 32'(od_coef_b[0]), 32'(eb0));
    chk({tag, ".b1"}, 32'(od_coef_b[1]), 32'(eb1));
    chk({tag, ".b2"}, 32'(od_coef_b[2]), 32'(eb2));
  endtask

  task automatic chk_pulses(input string tag, input logic va, input logic vb, input logic er);
    chk({tag, ".val_a"}, 32'(oc_val_coef_a), 32'(va));
    chk({tag, ".val_b"}, 32'(oc_val_coef_b), 32'(vb));
    chk({tag, ".err"},   32'(oc_err),        32'(er));
  endtask

  // Presents one byte (optionally with abort) and returns just after the accepting edge.
  task automatic send(input logic [7:0] b, input logic abort);
    int n = 0;
    @(negedge ic_clk);
    while (!oc_byte_rdy && n < 20) begin
      @(negedge ic_clk);
      n++;
    end
    chk("rdy_before_send", 32'(oc_byte_rdy), 32'd1);
    id_byte     = b;
    ic_byte_val = 1'b1;
    ic_abort    = abort;
    @(posedge ic_clk);
    #1;
    ic_byte_val = 1'b0;
    ic_abort    = 1'b0;
  endtask

  task automatic run_frame(input string tag, input vec_t v);
    logic [7:0] ck;
    logic [7:0] b;
    int n;
    ck = 8'h00;
    n  = int'(v.nb);
    for (int k = 0; k < n; k++) begin
      if (k > 0) repeat ($urandom_range(0, int'(v.gap))) @(posedge ic_clk);
      b  = v.by[8*(n-1-k) +: 8];
      ck = ck ^ b;
      send(b, 1'b0);
    end
`ifdef COEF_LOADER_CHECKSUM_EN
    if (v.ck) send(ck, 1'b0);
`endif
    @(negedge ic_clk);
    chk_pulses(tag, v.e_va, v.e_vb, v.e_err);
    chk({tag, ".rdy_commit"},  32'(oc_byte_rdy), 32'(!(v.e_va | v.e_vb)));
    chk({tag, ".busy_commit"}, 32'(oc_busy),     32'(v.e_va | v.e_vb));
    chk_coefs(tag, v.ea0, v.ea1, v.eb0, v.eb1, v.eb2);
    @(negedge ic_clk);
    chk_pulses({tag, ".after"}, 1'b0, 1'b0, 1'b0);
    chk({tag, ".rdy_after"},  32'(oc_byte_rdy), 32'd1);
    chk({tag, ".busy_after"}, 32'(oc_busy),     32'd0);
  endtask

  vec_t vecs[6];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = mkvec(104'hA1_07FFFFFF_00000010, 4'd9, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0,
                    27'h7FFFFFF, 27'h10, 27'h0, 27'h0, 27'h0);
    vecs[1] = mkvec(104'hB1_00000100_F8000000_07FFFFFE, 4'd13, 2'd3, 1'b1, 1'b0, 1'b0, 1'b1,
                    27'h7FFFFFF, 27'h10, 27'h100, 27'h0, 27'h7FFFFFE);
    vecs[2] = mkvec(104'h55, 4'd1, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0,
                    27'h7FFFFFF, 27'h10, 27'h100, 27'h0, 27'h7FFFFFE);
    vecs[3] = mkvec(104'hA1_00000003_7FFFFFFC, 4'd9, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0,
                    27'h3, 27'h7FFFFFC, 27'h100, 27'h0, 27'h7FFFFFE);
    vecs[4] = mkvec(104'hB1_FFFFFFFF_12345678_80000000, 4'd13, 2'd2, 1'b1, 1'b0, 1'b0, 1'b1,
                    27'h3, 27'h7FFFFFC, 27'h7FFFFFF, 27'h2345678, 27'h0);
    vecs[5] = mkvec(104'hA1_A1B10001_00000000, 4'd9, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0,
                    27'h1B10001, 27'h0, 27'h7FFFFFF, 27'h2345678, 27'h0);

    ic_rst_n    = 1'b0;
    id_byte     = 8'h00;
    ic_byte_val = 1'b0;
    ic_abort    = 1'b0;
    repeat (3) @(negedge ic_clk);
    chk("reset.rdy",  32'(oc_byte_rdy), 32'd0);
    chk("reset.busy", 32'(oc_busy),     32'd0);
    chk_pulses("reset", 1'b0, 1'b0, 1'b0);
    chk_coefs("reset", 27'h0, 27'h0, 27'h0, 27'h0, 27'h0);
    ic_rst_n = 1'b1;
    @(posedge ic_clk);

    for (int i = 0; i < 6; i++) run_frame($sformatf("vec%0d", i), vecs[i]);

    // Abort after header + 5 payload bytes: nothing committed, no error.
    send(8'hA1, 1'b0);
    send(8'h00, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b0); send(8'h05, 1'b0); send(8'h00, 1'b0);
    chk("abort.busy_mid", 32'(oc_busy), 32'd1);
    @(negedge ic_clk);
    ic_abort = 1'b1;
    @(posedge ic_clk);
    #1;
    ic_abort = 1'b0;
    @(negedge ic_clk);
    chk("abort.busy", 32'(oc_busy), 32'd0);
    chk_pulses("abort", 1'b0, 1'b0, 1'b0);
    chk_coefs("abort", 27'h1B10001, 27'h0, 27'h7FFFFFF, 27'h2345678, 27'h0);

    // Abort coincident with the final payload byte must win over the commit.
    send(8'hB1, 1'b0);
    for (int k = 0; k < 11; k++) send((k == 3) ? 8'h01 : ((k == 7) ? 8'h02 : 8'h00), 1'b0);
    send(8'h03, 1'b1);
    @(negedge ic_clk);
    chk("abortlast.busy", 32'(oc_busy), 32'd0);
    chk_pulses("abortlast", 1'b0, 1'b0, 1'b0);
    chk_coefs("abortlast", 27'h1B10001, 27'h0, 27'h7FFFFFF, 27'h2345678, 27'h0);

    run_frame("post_abort", mkvec(104'hA1_00000011_00000022, 4'd9, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0,
                                  27'h11, 27'h22, 27'h7FFFFFF, 27'h2345678, 27'h0));

    // Reset mid-frame clears outputs and drops the partial frame.
    send(8'hA1, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b0);
    @(negedge ic_clk);
    ic_rst_n = 1'b0;
    #1;
    chk("midrst.rdy",  32'(oc_byte_rdy), 32'd0);
    chk("midrst.busy", 32'(oc_busy),     32'd0);
    chk_pulses("midrst", 1'b0, 1'b0, 1'b0);
    chk_coefs("midrst", 27'h0, 27'h0, 27'h0, 27'h0, 27'h0);
    @(negedge ic_clk);
    ic_rst_n = 1'b1;
    @(posedge ic_clk);
    run_frame("post_rst", mkvec(104'hB1_00000001_00000002_00000003, 4'd13, 2'd1, 1'b1, 1'b0, 1'b0, 1'b1,
                                27'h0, 27'h0, 27'h1, 27'h2, 27'h3));

`ifdef COEF_LOADER_CHECKSUM_EN
    run_frame("ck_good", mkvec(104'hA1_00000001_00000002_A2, 4'd10, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0,
                               27'h1, 27'h2, 27'h1, 27'h2, 27'h3));
    run_frame("ck_bad", mkvec(104'hA1_00000005_00000006_A3, 4'd10, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0,
                              27'h1, 27'h2, 27'h1, 27'h2, 27'h3));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
